// File: rtl/utmi_pkg.sv
// Shared types and constants for the UTMI PHY-side transmit path.
package utmi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    DATA,
    EOP
  } utmi_tx_state_t;

  localparam logic [1:0] OPMODE_NORMAL   = 2'b00;
  localparam logic [1:0] OPMODE_NONDRIVE = 2'b01;
  localparam logic [1:0] OPMODE_NOSTUFF  = 2'b10;

  // Line symbols as {dp, dm}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

endpackage

// File: rtl/utmi_nrzi_stuff_enc.sv
// Bit-stuffing and NRZI encoder: one line level per advancing clock.
module utmi_nrzi_stuff_enc #(
  parameter int unsigned STUFF_LIMIT = 6,
  parameter int unsigned CNT_W       = $clog2(STUFF_LIMIT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             advance,
  input  logic             bypass,
  input  logic             clear,
  output logic             level,
  output logic             stuff_cycle,
  output logic [CNT_W-1:0] ones_cnt
);

  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_bit;

  assign stuff_cycle = advance & ~bypass & (cnt_q == CNT_W'(STUFF_LIMIT));
  assign tx_bit      = stuff_cycle ? 1'b0 : bit_in;
  assign ones_cnt    = cnt_q;

  // level 1 = J; in bypass the raw bit maps straight onto J/K
  always_comb begin
    level   = bypass ? tx_bit : (tx_bit ? level_q : ~level_q);
    level_d = level_q;
    cnt_d   = cnt_q;
    if (clear) begin
      level_d = 1'b1;
      cnt_d   = '0;
    end else if (advance) begin
      level_d = level;
      if (stuff_cycle || !tx_bit) begin
        cnt_d = '0;
      end else if (cnt_q != CNT_W'(STUFF_LIMIT)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/utmi_phy_tx.sv
// UTMI PHY transmit responder: accepts link bytes via TxValid/TxReady and
// serialises SYNC, stuffed/NRZI data and EOP onto the line at bit rate.
module utmi_phy_tx
  import utmi_pkg::*;
#(
  parameter int unsigned SYNC_BITS    = 8,
  parameter int unsigned EOP_SE0_BITS = 2,
  parameter int unsigned STUFF_LIMIT  = 6
) (
  input  logic       phy_clk_i,
  input  logic       phy_rst_i,
  input  logic [7:0] DataOut_i,
  input  logic       TxValid_i,
  output logic       TxReady_o,
  input  logic [1:0] OpMode_i,
  output logic       line_dp_o,
  output logic       line_dm_o,
  output logic       line_oe_o,
  output logic       tx_active_o
);

  localparam int unsigned ShW  = (SYNC_BITS > 8) ? SYNC_BITS : 8;
  localparam int unsigned IdxW = $clog2(ShW);
  localparam int unsigned CntW = $clog2(STUFF_LIMIT + 1);
  localparam int unsigned EopW = (EOP_SE0_BITS > 0) ? $clog2(EOP_SE0_BITS + 1) : 1;
  localparam logic [ShW-1:0] SyncPattern = ShW'(1) << (SYNC_BITS - 1);

  utmi_tx_state_t  state_q, state_d;
  logic [ShW-1:0]  shift_q, shift_d;
  logic [IdxW-1:0] bit_idx_q, bit_idx_d;
  logic [EopW-1:0] eop_cnt_q, eop_cnt_d;
  logic [1:0]      pkt_mode_q, pkt_mode_d;
  logic            end_pend_q, end_pend_d;

  logic            advance, bypass, last_bit, stuff_next;
  logic            level, stuff_cycle;
  logic [CntW-1:0] ones_cnt;

  assign advance  = (state_q == SYNC) || (state_q == DATA);
  assign bypass   = (pkt_mode_q == OPMODE_NOSTUFF);
  assign last_bit = (state_q == SYNC) ? (bit_idx_q == IdxW'(SYNC_BITS - 1))
                                      : (bit_idx_q == IdxW'(7));
  // The final bit of the packet will complete a run that still needs a stuff bit
  assign stuff_next = ~bypass & shift_q[0] & (ones_cnt == CntW'(STUFF_LIMIT - 1));

  utmi_nrzi_stuff_enc #(
    .STUFF_LIMIT(STUFF_LIMIT),
    .CNT_W      (CntW)
  ) u_enc (
    .clk        (phy_clk_i),
    .rst        (phy_rst_i),
    .bit_in     (shift_q[0]),
    .advance    (advance),
    .bypass     (bypass),
    .clear      (state_q == IDLE),
    .level      (level),
    .stuff_cycle(stuff_cycle),
    .ones_cnt   (ones_cnt)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    eop_cnt_d  = eop_cnt_q;
    pkt_mode_d = pkt_mode_q;
    end_pend_d = end_pend_q;
    case (state_q)
      IDLE: begin
        end_pend_d = 1'b0;
        eop_cnt_d  = '0;
        if (TxValid_i && (OpMode_i != OPMODE_NONDRIVE)) begin
          pkt_mode_d = (OpMode_i == OPMODE_NOSTUFF) ? OPMODE_NOSTUFF : OPMODE_NORMAL;
          shift_d    = SyncPattern;
          bit_idx_d  = '0;
          state_d    = SYNC;
        end
      end
      SYNC, DATA: begin
        if (stuff_cycle) begin
          if (end_pend_q) begin
            end_pend_d = 1'b0;
            eop_cnt_d  = '0;
            state_d    = EOP;
          end
        end else if (last_bit) begin
          if (TxValid_i) begin
            shift_d   = ShW'(DataOut_i);
            bit_idx_d = '0;
            state_d   = DATA;
          end else if (stuff_next) begin
            end_pend_d = 1'b1;
          end else begin
            eop_cnt_d = '0;
            state_d   = EOP;
          end
        end else begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      EOP: begin
        if (eop_cnt_q == EopW'(EOP_SE0_BITS)) begin
          state_d = IDLE;
        end else begin
          eop_cnt_d = eop_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    TxReady_o              = TxValid_i & advance & last_bit & ~stuff_cycle;
    {line_dp_o, line_dm_o} = LINE_J;
    line_oe_o              = 1'b0;
    case (state_q)
      SYNC, DATA: begin
        {line_dp_o, line_dm_o} = level ? LINE_J : LINE_K;
        line_oe_o              = 1'b1;
      end
      EOP: begin
        {line_dp_o, line_dm_o} = (eop_cnt_q == EopW'(EOP_SE0_BITS)) ? LINE_J : LINE_SE0;
        line_oe_o              = 1'b1;
      end
      default: ;
    endcase
  end

  assign tx_active_o = (state_q != IDLE);

  always_ff @(posedge phy_clk_i or posedge phy_rst_i) begin
    if (phy_rst_i) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      eop_cnt_q  <= '0;
      pkt_mode_q <= OPMODE_NORMAL;
      end_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      eop_cnt_q  <= eop_cnt_d;
      pkt_mode_q <= pkt_mode_d;
      end_pend_q <= end_pend_d;
    end
  end

endmodule

// File: tb/tb_utmi_phy_tx.sv
// Randomised bench for utmi_phy_tx against a bitstream-level reference model.
module tb_utmi_phy_tx;

  localparam logic [1:0] SYM_J   = 2'b10;
  localparam logic [1:0] SYM_K   = 2'b01;
  localparam logic [1:0] SYM_SE0 = 2'b00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_out = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [1:0] op_mode = 2'b00;
  logic       dp, dm, oe, active;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] pkt[$];
  logic [1:0] exp_sym[$];
  logic       exp_rdy[$];
  logic       m_lvl;

  utmi_phy_tx dut (
    .phy_clk_i  (clk),
    .phy_rst_i  (rst),
    .DataOut_i  (data_out),
    .TxValid_i  (tx_valid),
    .TxReady_o  (tx_ready),
    .OpMode_i   (op_mode),
    .line_dp_o  (dp),
    .line_dm_o  (dm),
    .line_oe_o  (oe),
    .tx_active_o(active)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic push_bit(input logic b, input logic rdy, input bit raw);
    if (raw) begin
      exp_sym.push_back(b ? SYM_J : SYM_K);
    end else begin
      if (!b) m_lvl = ~m_lvl;
      exp_sym.push_back(m_lvl ? SYM_J : SYM_K);
    end
    exp_rdy.push_back(rdy);
  endtask

  // Expected line stream: SYNC + bytes LSB-first, stuff after every 6th one, NRZI, then EOP
  task automatic build_model(input logic [1:0] mode);
    int   ones;
    logic b;
    bit   raw;
    raw   = (mode == 2'b10);
    ones  = 0;
    m_lvl = 1'b1;
    exp_sym.delete();
    exp_rdy.delete();
    for (int u = 0; u <= pkt.size(); u++) begin
      for (int k = 0; k < 8; k++) begin
        b = (u == 0) ? (k == 7) : pkt[u-1][k];
        push_bit(b, (k == 7) && (u < pkt.size()), raw);
        ones = b ? ones + 1 : 0;
        if (!raw && ones == 6) begin
          push_bit(1'b0, 1'b0, raw);
          ones = 0;
        end
      end
    end
    for (int e = 0; e < 2; e++) begin
      exp_sym.push_back(SYM_SE0);
      exp_rdy.push_back(1'b0);
    end
    exp_sym.push_back(SYM_J);
    exp_rdy.push_back(1'b0);
  endtask

  task automatic run_pkt(input logic [1:0] mode, input int exp_oe_len, input int exp_pulses);
    int   ptr, oe_len, pulses;
    logic seen;
    build_model(mode);
    @(posedge clk); #1;
    op_mode  = mode;
    data_out = pkt[0];
    tx_valid = 1'b1;
    ptr = 0; oe_len = 0; pulses = 0;
    @(negedge clk);
    check_eq("idle_start", 32'({tx_ready, oe, active}), 32'(3'b000));
    @(posedge clk); #1;
    op_mode = 2'($urandom_range(0, 3));  // must not affect the packet in flight
    for (int i = 0; i < exp_sym.size(); i++) begin
      @(negedge clk);
      check_eq("pkt_bit", 32'({tx_ready, dp, dm, oe, active}),
               32'({exp_rdy[i], exp_sym[i], 1'b1, 1'b1}));
      if (oe) oe_len++;
      seen = tx_ready;
      if (seen) pulses++;
      @(posedge clk); #1;
      if (seen) begin
        ptr++;
        if (ptr < pkt.size()) data_out = pkt[ptr];
        else begin
          tx_valid = 1'b0;
          data_out = 8'($urandom);
        end
      end
    end
    @(negedge clk);
    check_eq("eop_idle", 32'({oe, active, dp, dm, tx_ready}), 32'(5'b00100));
    if (exp_oe_len >= 0) check_eq("oe_len", 32'(oe_len), 32'(exp_oe_len));
    if (exp_pulses >= 0) check_eq("rdy_pulses", 32'(pulses), 32'(exp_pulses));
    tx_valid = 1'b0;
  endtask

  initial begin
    int   r;
    logic [1:0] m;

    #3;
    check_eq("reset_out", 32'({tx_ready, dp, dm, oe, active}), 32'(5'b01000));
    @(posedge clk); #1;
    rst = 1'b0;

    pkt = '{8'h00, 8'h00}; run_pkt(2'b00, 27, 2);
    pkt = '{8'hFF};        run_pkt(2'b00, 20, 1);
    pkt = '{8'hFF};        run_pkt(2'b10, 19, 1);
    pkt = '{8'h3F};        run_pkt(2'b00, 20, 1);
    pkt = '{8'hFC};        run_pkt(2'b00, 20, 1);  // stuff bit lands just before EOP
    pkt = '{8'hA5, 8'h5A}; run_pkt(2'b11, 27, 2);

    for (int p = 0; p < 25; p++) begin
      pkt.delete();
      r = $urandom_range(1, 4);
      for (int j = 0; j < r; j++)
        pkt.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      r = $urandom_range(0, 2);
      m = (r == 0) ? 2'b00 : (r == 1) ? 2'b10 : 2'b11;
      run_pkt(m, -1, -1);
    end

    // Non-driving mode holds the block idle
    @(posedge clk); #1;
    op_mode  = 2'b01;
    tx_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      check_eq("nondrive", 32'({tx_ready, oe, active, dp, dm}), 32'(5'b00010));
    end
    @(posedge clk); #1;
    tx_valid = 1'b0;
    op_mode  = 2'b00;

    // Reset while in DATA at bit_idx 3
    @(posedge clk); #1;
    data_out = 8'h00;
    tx_valid = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check_eq("rst_mid", 32'({tx_ready, dp, dm, oe, active}), 32'(5'b01000));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("rst_hold", 32'({tx_ready, oe, active}), 32'(3'b000));
    end
    @(posedge clk); #1;
    rst      = 1'b0;
    tx_valid = 1'b0;
    pkt = '{8'hA5}; run_pkt(2'b00, 19, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
